tone_scheduler: RTL and testbench

Beat-rate scheduler that shares the single tone generator between the background melody sequencer and two sound-effect requesters. Generates the melody step pulse, arbitrates effect requests on beat boundaries, and drives the 5-bit note index (0-24 pitch, 25 = rest) into the tone generator. Sits between the melody sequencer, the game-logic effect sources and the tone generator.

---
 rtl/tone_sched_if.sv | 27 ++
 rtl/tone_scheduler.sv | 94 +++++++++
 tb/tb_tone_scheduler.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tone_sched_if.sv
// tone_sched_if: melody, effect-requester and tone-generator signals around tone_scheduler
interface tone_sched_if;
  logic       play;
  logic       restart;
  logic [4:0] music_note;
  logic       music_step;
  logic       music_clr;
  logic       sfx0_req;
  logic       sfx1_req;
  logic [4:0] sfx0_note;
  logic [4:0] sfx1_note;
  logic [3:0] sfx0_beats;
  logic [3:0] sfx1_beats;
  logic       sfx0_ack;
  logic       sfx1_ack;
  logic [4:0] note_out;
  logic [1:0] src;
  logic       busy;
  modport slave (
    input  play, restart, music_note, sfx0_req, sfx1_req, sfx0_note, sfx1_note, sfx0_beats, sfx1_beats,
    output music_step, music_clr, sfx0_ack, sfx1_ack, note_out, src, busy
  );
  modport master (
    output play, restart, music_note, sfx0_req, sfx1_req, sfx0_note, sfx1_note, sfx0_beats, sfx1_beats,
    input  music_step, music_clr, sfx0_ack, sfx1_ack, note_out, src, busy
  );
endinterface

// File: rtl/tone_scheduler.sv
// tone_scheduler: beat-rate sharing of one tone generator between melody and two effects; TONE_SCHED_RR_EN selects round-robin effect arbitration
module tone_scheduler #(
  parameter int CLK_DIV = 10000000
) (
  input  logic        clk,
  input  logic        rst_n,
  tone_sched_if.slave bus
);
  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
  localparam logic [4:0] REST = 5'd25;
  typedef enum logic [1:0] {IDLE, MUSIC, SFX} state_t;
  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [3:0]   rem_q, rem_d;
  logic [4:0]   note_q, note_d;
  logic [1:0]   src_q, src_d;
  logic         busy_q, busy_d, step_q, step_d, clr_q, clr_d;
  logic         ack0_q, ack0_d, ack1_q, ack1_d;
  logic         tick, decide, grant, pick1;
  logic [4:0]   pick_note;
  logic [3:0]   pick_beats;
`ifdef TONE_SCHED_RR_EN
  logic last1_q, last1_d;
  assign pick1   = bus.sfx1_req & (~bus.sfx0_req | ~last1_q);
  assign last1_d = bus.restart ? 1'b1 : grant ? pick1 : last1_q;
  // remembers whether sfx1 won the most recent grant so a tie goes the other way
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last1_q <= 1'b1;
    else last1_q <= last1_d;
`else
  assign pick1 = bus.sfx1_req & ~bus.sfx0_req;
`endif
  assign tick       = cnt_q == LAST;
  assign decide     = tick & ~bus.restart & ((state_q != SFX) | (rem_q == 4'd1));
  assign grant      = decide & (bus.sfx0_req | bus.sfx1_req);
  assign pick_note  = pick1 ? bus.sfx1_note : bus.sfx0_note;
  assign pick_beats = pick1 ? bus.sfx1_beats : bus.sfx0_beats;
  assign cnt_d      = (bus.restart | tick) ? '0 : cnt_q + 1'b1;
  // state and registered outputs; restart is handled through the _d terms
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= 4'd0;
      note_q  <= REST;
      src_q   <= 2'd0;
      busy_q  <= 1'b0;
      step_q  <= 1'b0;
      clr_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      note_q  <= note_d;
      src_q   <= src_d;
      busy_q  <= busy_d;
      step_q  <= step_d;
      clr_q   <= clr_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  // next state: effects preempt on beat boundaries, an effect counts its beats down
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (bus.restart) state_d = IDLE;
    else if (grant) begin
      state_d = SFX;
      rem_d   = pick_beats == 4'd0 ? 4'd1 : pick_beats;
    end else if (decide) state_d = bus.play ? MUSIC : IDLE;
    else if (tick && state_q == SFX) rem_d = rem_q - 4'd1;
  end
  // output next values; the melody note is copied every cycle while music plays
  always_comb begin
    step_d = decide & ~grant & bus.play & (state_q == MUSIC);
    clr_d  = bus.restart;
    ack0_d = grant & ~pick1;
    ack1_d = grant & pick1;
    busy_d = state_d == SFX;
    note_d = grant ? (pick_note > REST ? REST : pick_note) :
             state_d == MUSIC ? bus.music_note : state_d == IDLE ? REST : note_q;
    src_d  = grant ? {1'b1, pick1} : state_d == MUSIC ? 2'd1 : state_d == IDLE ? 2'd0 : src_q;
  end
  assign bus.note_out   = note_q;
  assign bus.src        = src_q;
  assign bus.busy       = busy_q;
  assign bus.music_step = step_q;
  assign bus.music_clr  = clr_q;
  assign bus.sfx0_ack   = ack0_q;
  assign bus.sfx1_ack   = ack1_q;
endmodule

// File: tb/tb_tone_scheduler.sv
// tb_tone_scheduler: randomized scenario checks of tone_scheduler against spec-level expectations
module tb_tone_scheduler;
  localparam int CD = 4;
`ifdef TONE_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int edges = 0;
  int n_checks = 0;
  int n_fail = 0;
  tone_sched_if bus();
  tone_scheduler #(.CLK_DIV(CD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  wire [11:0] obs = {bus.note_out, bus.src, bus.busy, bus.music_step, bus.music_clr, bus.sfx0_ack, bus.sfx1_ack};
  localparam logic [11:0] IDLE_O = {5'd25, 2'd0, 5'b00000};

  function automatic logic [11:0] exp_o(input logic [4:0] n, input logic [1:0] s, input logic b, input logic st,
                                        input logic cl, input logic a0, input logic a1);
    return {n, s, b, st, cl, a0, a1};
  endfunction

  function automatic bit tick_edge();
    return edges != 0 && edges % CD == 0;
  endfunction

  task automatic cyc();
    logic r;
    r = bus.restart;
    @(posedge clk);
    #1;
    edges = r ? 0 : edges + 1;
  endtask

  task automatic wait_ack(input int who, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      cyc();
      if (bus.sfx0_ack || bus.sfx1_ack) begin
        ok = 1'b1;
        n_checks++;
        if ({bus.sfx0_ack, bus.sfx1_ack} !== (who == 0 ? 2'b10 : 2'b01) || !tick_edge()) begin
          n_fail++;
          $display("FAIL ack_grant: got acks %b at edge %0d, exp sfx%0d on a beat edge", {bus.sfx0_ack, bus.sfx1_ack}, edges, who);
        end
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_timeout: got no ack in %0d cycles, exp sfx%0d ack", budget, who);
    end
  endtask

  task automatic hold_effect(input int who, input logic [4:0] n, input logic [3:0] b, input bit reassert);
    logic [4:0] en;
    int len;
    en = n > 5'd25 ? 5'd25 : n;
    len = (b == 4'd0 ? 1 : int'(b)) * CD;
    if (who == 0) bus.sfx0_req = 1'b0; else bus.sfx1_req = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (i > 0) cyc();
      if (i == 1 && reassert) begin
        if (who == 0) bus.sfx0_req = 1'b1; else bus.sfx1_req = 1'b1;
      end
      n_checks++;
      if (obs !== exp_o(en, 2'(who + 2), 1'b1, 1'b0, 1'b0, i == 0 && who == 0, i == 0 && who == 1)) begin
        n_fail++;
        $display("FAIL effect_hold sfx%0d cycle %0d: got %h exp %h", who, i,
                 obs, exp_o(en, 2'(who + 2), 1'b1, 1'b0, 1'b0, i == 0 && who == 0, i == 0 && who == 1));
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== IDLE_O) begin n_fail++; $display("FAIL reset_values: got %h exp %h", obs, IDLE_O); end
    rst_n = 1'b1;
    edges = 0;
    for (int i = 1; i < CD; i++) begin
      cyc();
      n_checks++;
      if (obs !== IDLE_O) begin n_fail++; $display("FAIL reset_idle cycle %0d: got %h exp %h", i, obs, IDLE_O); end
    end
  endtask

  task automatic test_music();
    logic [4:0] m;
    bit in_music, was;
    in_music = 1'b0;
    bus.play = 1'b1;
    for (int i = 0; i < 6 * CD; i++) begin
      m = 5'($urandom_range(0, 24));
      bus.music_note = m;
      was = in_music;
      cyc();
      if (tick_edge()) in_music = 1'b1;
      n_checks++;
      if (obs !== exp_o(in_music ? m : 5'd25, in_music ? 2'd1 : 2'd0, 1'b0, was && tick_edge(), 1'b0, 1'b0, 1'b0)) begin
        n_fail++;
        $display("FAIL music edge %0d: got %h exp %h", edges, obs,
                 exp_o(in_music ? m : 5'd25, in_music ? 2'd1 : 2'd0, 1'b0, was && tick_edge(), 1'b0, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic test_sfx_in_music();
    logic [4:0] m, n;
    logic [3:0] b;
    bit ok;
    m = 5'($urandom_range(0, 24));
    n = 5'($urandom_range(0, 24));
    b = 4'($urandom_range(1, 3));
    bus.music_note = m;
    bus.sfx1_note = n;
    bus.sfx1_beats = b;
    bus.sfx1_req = 1'b1;
    wait_ack(1, 2 * CD, ok);
    if (ok) begin
      hold_effect(1, n, b, 1'b0);
      for (int i = 0; i <= CD; i++) begin
        cyc();
        n_checks++;
        if (obs !== exp_o(m, 2'd1, 1'b0, i == CD, 1'b0, 1'b0, 1'b0)) begin
          n_fail++;
          $display("FAIL music_resume cycle %0d: got %h exp %h", i, obs, exp_o(m, 2'd1, 1'b0, i == CD, 1'b0, 1'b0, 1'b0));
        end
      end
    end
  endtask

  task automatic test_arbitration();
    logic [4:0] n0, n1;
    logic [3:0] b0, b1;
    bit ok;
    int win, last;
    bus.play = 1'b0;
    n0 = 5'($urandom_range(0, 24));
    n1 = 5'($urandom_range(0, 24));
    bus.sfx0_note = n0; bus.sfx0_beats = 4'd1;
    bus.sfx1_note = n1; bus.sfx1_beats = 4'd1;
    bus.sfx0_req = 1'b1; bus.sfx1_req = 1'b1;
    wait_ack(0, 2 * CD, ok);
    if (ok) hold_effect(0, n0, 4'd1, 1'b0);
    wait_ack(1, 1, ok);
    if (ok) hold_effect(1, n1, 4'd1, 1'b0);
    cyc();
    n_checks++;
    if (obs !== IDLE_O) begin n_fail++; $display("FAIL arb_idle: got %h exp %h", obs, IDLE_O); end
    n0 = 5'($urandom_range(0, 24)); b0 = 4'($urandom_range(0, 2));
    n1 = 5'($urandom_range(0, 24)); b1 = 4'($urandom_range(0, 2));
    bus.sfx0_note = n0; bus.sfx0_beats = b0;
    bus.sfx1_note = n1; bus.sfx1_beats = b1;
    bus.sfx0_req = 1'b1; bus.sfx1_req = 1'b1;
    last = 1;
    for (int k = 0; k < 3; k++) begin
      win = RR ? (last == 0 ? 1 : 0) : 0;
      wait_ack(win, k == 0 ? 2 * CD : 1, ok);
      if (!ok) break;
      hold_effect(win, win == 0 ? n0 : n1, win == 0 ? b0 : b1, k < 2);
      last = win;
    end
    bus.sfx0_req = 1'b0;
    bus.sfx1_req = 1'b0;
    cyc();
  endtask

  task automatic test_clamp();
    logic [4:0] n;
    bit ok;
    bus.play = 1'b0;
    n = 5'($urandom_range(26, 31));
    bus.sfx0_note = n;
    bus.sfx0_beats = 4'd0;
    bus.sfx0_req = 1'b1;
    wait_ack(0, 2 * CD, ok);
    if (ok) begin
      hold_effect(0, n, 4'd0, 1'b0);
      cyc();
      n_checks++;
      if (obs !== IDLE_O) begin n_fail++; $display("FAIL clamp_end: got %h exp %h", obs, IDLE_O); end
    end
  endtask

  task automatic test_restart();
    logic [4:0] n0, n1;
    bit ok;
    bus.play = 1'b1;
    n0 = 5'($urandom_range(0, 24));
    n1 = 5'($urandom_range(0, 24));
    bus.sfx0_note = n0;
    bus.sfx0_beats = 4'($urandom_range(2, 5));
    bus.sfx0_req = 1'b1;
    wait_ack(0, 2 * CD, ok);
    bus.sfx0_req = 1'b0;
    for (int i = 0; i < CD && (edges + 1) % CD != 0; i++) cyc();
    bus.sfx1_note = n1;
    bus.sfx1_beats = 4'd3;
    bus.sfx1_req = 1'b1;
    bus.restart = 1'b1;
    cyc();
    bus.restart = 1'b0;
    n_checks++;
    if (obs !== exp_o(5'd25, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL restart_edge: got %h exp %h", obs, exp_o(5'd25, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    end
    for (int i = 1; i <= CD; i++) begin
      cyc();
      n_checks++;
      if (obs !== (i == CD ? exp_o(n1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1) : IDLE_O)) begin
        n_fail++;
        $display("FAIL restart_next_tick cycle %0d: got %h exp %h", i, obs,
                 i == CD ? exp_o(n1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1) : IDLE_O);
      end
    end
    bus.sfx1_req = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [4:0] m;
    m = 5'($urandom_range(0, 24));
    bus.music_note = m;
    bus.play = 1'b1;
    repeat (2) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== IDLE_O) begin n_fail++; $display("FAIL async_reset: got %h exp %h", obs, IDLE_O); end
    rst_n = 1'b1;
    edges = 0;
    for (int i = 1; i <= CD; i++) begin
      cyc();
      n_checks++;
      if (obs !== (i == CD ? exp_o(m, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0) : IDLE_O)) begin
        n_fail++;
        $display("FAIL post_reset_tick cycle %0d: got %h exp %h", i, obs,
                 i == CD ? exp_o(m, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0) : IDLE_O);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.play = 1'b0;
    bus.restart = 1'b0;
    bus.music_note = 5'd0;
    bus.sfx0_req = 1'b0;
    bus.sfx1_req = 1'b0;
    bus.sfx0_note = 5'd0;
    bus.sfx1_note = 5'd0;
    bus.sfx0_beats = 4'd0;
    bus.sfx1_beats = 4'd0;
    test_reset();
    test_music();
    test_sfx_in_music();
    test_arbitration();
    test_clamp();
    test_restart();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
